// File: rtl/dbus_sram_responder_pkg.sv
// Data-bus payload types shared by the memory stage and its responders.
package dbus_sram_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response bundle between the memory stage and a responder.
interface dbus_sram_responder_if;
  import dbus_sram_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a 64-bit-wide SRAM array with fixed access latency.
// One transaction at a time: IDLE accepts, WAIT counts down, RESP pulses data_ok.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  dbus_sram_responder_if.slave  dbus,
  input  logic                  hold,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  if (LATENCY == 0) begin : g_bad_latency
    $error("dbus_sram_responder: LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [ADDR_BITS-1:0] r_idx;
  logic [7:0]           r_strobe;
  logic [63:0]          r_wdata;
  logic [63:0]          r_rdata;
  logic [63:0]          r_mem [DEPTH];
  logic                 w_accept;
  logic                 w_access;
  dbus_resp_t           w_resp;

  // Byte offset, size and address bits above the array are deliberately ignored.
  logic w_unused;
  assign w_unused = &{1'b0, dbus.dreq.addr[63:ADDR_BITS+3], dbus.dreq.addr[2:0], dbus.dreq.size};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    w_resp      = '0;
    case (r_state)
      S_IDLE: begin
        w_resp.addr_ok = dbus.dreq.valid;
        if (dbus.dreq.valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!hold) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_access    = 1'b1;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        w_resp.data_ok = 1'b1;
        w_resp.data    = r_rdata;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign dbus.dresp = w_resp;
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_strobe <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx    <= dbus.dreq.addr[ADDR_BITS+2:3];
        r_strobe <= dbus.dreq.strobe;
        r_wdata  <= dbus.dreq.data;
      end
      if (w_access) begin
        r_rdata <= (r_strobe != '0) ? 64'd0 : r_mem[r_idx];
      end
    end
  end

  // Array is not reset; an async reset forces IDLE, which suppresses any pending write.
  always_ff @(posedge clk) begin
    if (w_access && (r_strobe != '0)) begin
      for (int i = 0; i < 8; i++) begin
        if (r_strobe[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule
